// File: rtl/regfile_b_write_port_pkg.sv
// Shared types for the port-B write path: command encoding, write-entry struct
// and queue depth.
package regfileBGroup;

    typedef enum logic [1:0] {
        NO_OP      = 2'b00,
        RESULT_DRH = 2'b01,
        CALC_SRA   = 2'b10,
        RESERVED   = 2'b11
    } controlBus;

    typedef struct packed {
        logic [4:0]  index;
        logic [31:0] data;
    } writeEntry_t;

    localparam int QUEUE_DEPTH = 2;

    function automatic logic isWriteCmd(input controlBus cmd);
        return (cmd == RESULT_DRH) || (cmd == CALC_SRA);
    endfunction

endpackage

// File: rtl/regfile_b_write_port_if.sv
// Request and write-back signals of the port-B write path; the block is the
// slave, the issuing stage/bench is the master.
interface regfile_b_write_port_if;

    logic                   enable;
    regfileBGroup::controlBus regfileBControl;
    logic [4:0]             drhIndex;
    logic [4:0]             sraIndex;
    logic [31:0]            resultHigh;
    logic [31:0]            calcAddress;
    logic                   portAWriteEn;
    logic [4:0]             portAWriteIndex;
    logic                   regWriteEn;
    logic [4:0]             regWriteIndex;
    logic [31:0]            regWriteData;
    logic [1:0]             queueCount;
    logic                   stallRequest;
    logic                   overflow;

    modport master (
        output enable, regfileBControl, drhIndex, sraIndex, resultHigh, calcAddress,
               portAWriteEn, portAWriteIndex,
        input  regWriteEn, regWriteIndex, regWriteData, queueCount, stallRequest, overflow
    );

    modport slave (
        input  enable, regfileBControl, drhIndex, sraIndex, resultHigh, calcAddress,
               portAWriteEn, portAWriteIndex,
        output regWriteEn, regWriteIndex, regWriteData, queueCount, stallRequest, overflow
    );

endinterface

// File: rtl/regfile_b_write_queue.sv
// Two-entry FIFO of deferred port-B writes; supports push and pop on the same edge.
module regfile_b_write_queue
    import regfileBGroup::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  writeEntry_t entry_i,
    output writeEntry_t head_o,
    output logic [1:0]  count_o
);

    writeEntry_t mem_q [QUEUE_DEPTH];
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (push_i) wrPtr_d = ~wrPtr_q;
        if (pop_i)  rdPtr_d = ~rdPtr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is qualified by the control state, so it needs no reset; when full
    // with a simultaneous pop, the popped slot is the one being rewritten.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wrPtr_q] <= entry_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_b_write_port.sv
// Register-file port-B write arbiter: defers writes that collide with port A
// into an in-order two-entry queue and emits one registered write per cycle.
module regfile_b_write_port
    import regfileBGroup::*;
(
    input  logic                   clk,
    input  logic                   reset,
    regfile_b_write_port_if.slave  bus
);

    writeEntry_t newEntry, head, regWriteEntry_q, regWriteEntry_d;
    logic        newValid, conflictHead, conflictNew;
    logic        selHead, selNew, push, pop, full;
    logic [1:0]  count;
    logic        regWriteEn_q, regWriteEn_d;
    logic        overflow_q, overflow_d;

    assign full = (count == 2'(QUEUE_DEPTH));

    always_comb begin
        newValid        = bus.enable && isWriteCmd(bus.regfileBControl);
        newEntry        = '0;
        if (bus.regfileBControl == CALC_SRA) begin
            newEntry.index = bus.sraIndex;
            newEntry.data  = bus.calcAddress;
        end else begin
            newEntry.index = bus.drhIndex;
            newEntry.data  = bus.resultHigh;
        end

        conflictHead    = bus.portAWriteEn && (bus.portAWriteIndex == head.index);
        conflictNew     = bus.portAWriteEn && (bus.portAWriteIndex == newEntry.index);

        // The queue head always goes first so no request overtakes an older one.
        selHead         = (count != 2'd0) && !conflictHead;
        selNew          = (count == 2'd0) && newValid && !conflictNew;
        pop             = selHead;
        push            = newValid && !selNew && !(full && !pop);

        overflow_d      = overflow_q || (newValid && !selNew && full && !pop);
        regWriteEn_d    = selHead || selNew;
        regWriteEntry_d = regWriteEntry_q;
        if (selHead)     regWriteEntry_d = head;
        else if (selNew) regWriteEntry_d = newEntry;
    end

    regfile_b_write_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .entry_i (newEntry),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteEn_q    <= 1'b0;
            regWriteEntry_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            regWriteEn_q    <= regWriteEn_d;
            regWriteEntry_q <= regWriteEntry_d;
            overflow_q      <= overflow_d;
        end
    end

    assign bus.regWriteEn    = regWriteEn_q;
    assign bus.regWriteIndex = regWriteEntry_q.index;
    assign bus.regWriteData  = regWriteEntry_q.data;
    assign bus.queueCount    = count;
    assign bus.stallRequest  = full;
    assign bus.overflow      = overflow_q;

endmodule

// File: doc/regfile_b_write_port.md
REGFILE_B_WRITE_PORT -- requirements
Module: regfile_b_write_port

Interface
REQ-001 SHALL provide port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL provide port reset, input, 1, asynchronous, active-high.
REQ-003 SHALL provide port enable, input, 1, pipeline advance (low = stall, request ignored).
REQ-004 SHALL provide port regfileBControl, input, regfileBGroup::controlBus, port-B write command.
REQ-005 SHALL provide port drhIndex, input, 5, destination index for RESULT_DRH.
REQ-006 SHALL provide port sraIndex, input, 5, base-register index for CALC_SRA.
REQ-007 SHALL provide port resultHigh, input, 32, high multiply/divide result.
REQ-008 SHALL provide port calcAddress, input, 32, computed effective address.
REQ-009 SHALL provide ports portAWriteEn (input, 1) and portAWriteIndex (input, 5), the port-A write issued at the same edge.
REQ-010 SHALL provide ports regWriteEn (output, 1), regWriteIndex (output, 5) and regWriteData (output, 32), the registered port-B write.
REQ-011 SHALL provide ports queueCount (output, 2, entries held 0..2), stallRequest (output, 1, high when queueCount==2) and overflow (output, 1, sticky).

Function
REQ-012 SHALL decode a request only when enable=1: RESULT_DRH -> {drhIndex, resultHigh}; CALC_SRA -> {sraIndex, calcAddress}; NO_OP and the reserved encoding -> none.
REQ-013 SHALL register all write outputs; a request sampled at edge N appears on regWrite* during cycle N+1 at the earliest.
REQ-014 SHALL define conflict(idx) as portAWriteEn=1 and portAWriteIndex==idx at the same edge; port A always has priority.
REQ-015 SHALL, per edge, select in priority order: queue head if queue non-empty and no conflict(head); else the new request if queue empty and no conflict(new); else no write (regWriteEn=0).
REQ-016 SHALL enqueue a new request that was not selected, preserving strict program order (no new request bypasses a queued entry).
REQ-017 SHALL allow enqueue and dequeue at the same edge; queueCount unchanged in that case.
REQ-018 SHALL, on a request that must be enqueued while queueCount==2 and no dequeue occurs, drop the request and set overflow until reset.
REQ-019 SHALL drain queued entries while enable=0 (draining is independent of enable).
REQ-020 SHALL hold regWriteIndex/regWriteData at last value when regWriteEn=0.

Reset
REQ-021 SHALL on reset drive regWriteEn=0, regWriteIndex=0, regWriteData=0, queueCount=0, stallRequest=0 and overflow=0, and discard all queued entries.
REQ-022 SHALL have reset take effect immediately, including mid-drain; no queued write is emitted after reset asserts.

Structure
REQ-023 SHALL use the regfileBGroup package encoding: NO_OP=2'b00, RESULT_DRH=2'b01, CALC_SRA=2'b10, 2'b11 reserved.
REQ-024 SHALL place the write-entry struct {index[4:0], data[31:0]} and the queue depth constant (2) in regfileBGroup.
REQ-025 SHALL implement the queue as one sub-module, regfile_b_write_queue (2-entry FIFO, push/pop/count).

Verification
REQ-026 SHALL cover: RESULT_DRH, drhIndex=5, resultHigh=0xDEADBEEF, no port-A write -> next cycle regWriteEn=1, index 5, data 0xDEADBEEF, queueCount=0.
REQ-027 SHALL cover: CALC_SRA, sraIndex=3, calcAddress=0x1000, port-A writing index 3 same edge -> no write, queueCount=1; next cycle (no conflict) write index 3 data 0x1000.
REQ-028 SHALL cover: two requests (indices 7, 8) both conflicted, then a third (index 9) with port A idle -> writes emitted 7, 8, 9 in order, stallRequest high while count==2.
REQ-029 SHALL cover: queue full plus a conflicted new request (index 10) -> request dropped, overflow=1 persists until reset.
REQ-030 SHALL cover: enable=0 with RESULT_DRH on the bus -> no write, no enqueue; the queued entry still drains.
REQ-031 SHALL cover: reset asserted with queueCount=2 -> all outputs 0 immediately, no queued write emitted after reset deasserts.
